// File: rtl/network_run_controller.sv
// Command-driven sequencer for the spiking network: turns SPIKE/RUN/CLEAR commands
// into per-step enables and streams captured outputs. Optional counters: RUN_CTRL_STATS_EN.
module network_run_controller #(
    parameter int NUM_INP    = 8,
    parameter int NUM_OUT    = 8,
    parameter int RUN_WIDTH  = 16,
    parameter int CLR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [NUM_INP-1:0]   cmd_spk,
    input  logic [RUN_WIDTH-1:0] cmd_run,
    output logic                 net_en,
    output logic                 net_clr,
    output logic [NUM_INP-1:0]   net_inp,
    input  logic [NUM_OUT-1:0]   net_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_OUT-1:0]   out_data,
    output logic                 out_last,
    output logic                 busy
`ifdef RUN_CTRL_STATS_EN
    ,
    output logic [31:0]          stat_steps,
    output logic [31:0]          stat_stalls
`endif
);

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [RUN_WIDTH-1:0] COUNT_ONE = RUN_WIDTH'(1);
    localparam logic [CW-1:0]        CCNT_INIT = CW'(CLR_CYCLES - 1);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_SPIKE = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t                 r_state;
    logic [RUN_WIDTH-1:0]   r_count;
    logic [NUM_INP-1:0]     r_pending;
    logic                   r_first;
    logic [CW-1:0]          r_ccnt;
    logic                   r_out_valid;
    logic [NUM_OUT-1:0]     r_out_data;
    logic                   r_out_last;

    logic                   w_accept;
    logic                   w_step;

    // A step may only be taken when the output register is free or being drained.
    assign w_step    = (r_state == S_RUN) && (!r_out_valid || out_ready) && !rst;
    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    assign net_en    = w_step;
    assign net_clr   = rst || (r_state == S_CLEAR);
    assign net_inp   = (w_step && r_first) ? r_pending : '0;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_pending   <= '0;
            r_first     <= 1'b0;
            r_ccnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_step) begin
                r_out_data  <= net_out;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_count == COUNT_ONE);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (cmd_op)
                            OP_SPIKE: r_pending <= r_pending | cmd_spk;
                            OP_RUN: begin
                                // A zero-length run is a no-op and never leaves IDLE.
                                if (cmd_run != '0) begin
                                    r_count <= cmd_run;
                                    r_first <= 1'b1;
                                    r_state <= S_RUN;
                                end
                            end
                            OP_CLEAR: begin
                                r_pending <= '0;
                                r_ccnt    <= CCNT_INIT;
                                r_state   <= S_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (w_step) begin
                        r_count   <= r_count - COUNT_ONE;
                        r_first   <= 1'b0;
                        r_pending <= '0;
                        if (r_count == COUNT_ONE) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_CLEAR: begin
                    if (r_ccnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ccnt <= r_ccnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef RUN_CTRL_STATS_EN
    logic [31:0] r_stat_steps;
    logic [31:0] r_stat_stalls;

    // Saturating counters; only rst clears them, CLEAR commands leave them intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_steps  <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_step && (r_stat_steps != 32'hFFFF_FFFF)) begin
                r_stat_steps <= r_stat_steps + 32'd1;
            end
            if ((r_state == S_RUN) && !w_step && (r_stat_stalls != 32'hFFFF_FFFF)) begin
                r_stat_stalls <= r_stat_stalls + 32'd1;
            end
        end
    end

    assign stat_steps  = r_stat_steps;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_network_run_controller.sv
// Directed self-checking bench for network_run_controller; stats checks are
// compiled in when RUN_CTRL_STATS_EN is defined.
module tb_network_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_spk;
    logic [15:0] cmd_run;
    logic        net_en;
    logic        net_clr;
    logic [7:0]  net_inp;
    logic [7:0]  net_out;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
`ifdef RUN_CTRL_STATS_EN
    logic [31:0] stat_steps;
    logic [31:0] stat_stalls;
`endif

    network_run_controller #(
        .NUM_INP(8), .NUM_OUT(8), .RUN_WIDTH(16), .CLR_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_spk(cmd_spk), .cmd_run(cmd_run),
        .net_en(net_en), .net_clr(net_clr), .net_inp(net_inp), .net_out(net_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
`ifdef RUN_CTRL_STATS_EN
        , .stat_steps(stat_steps), .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign net_out = cyc[7:0] ^ 8'h5A;

    int n_cmp = 0;
    int n_bad = 0;

    int         en_q[$];
    logic [7:0] inp_q[$];
    logic [7:0] exp_q[$];
    logic       last_q[$];
    int         clr_cnt = 0;
    int         inp_viol = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every net_en pushes the value the DUT must capture; every
    // output handshake pops and compares it.
    always @(negedge clk) begin
        if (!rst) begin
            if (net_en) begin
                en_q.push_back(cyc);
                inp_q.push_back(net_inp);
                exp_q.push_back(net_out);
            end else if (net_inp != 8'h00) begin
                inp_viol++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("out_orphan", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_val("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    last_q.push_back(out_last);
                end
            end
            if (net_clr) clr_cnt++;
        end
    end

    function automatic logic [31:0] inp_at(int i);
        return (i < inp_q.size()) ? 32'(inp_q[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] last_at(int i);
        return (i < last_q.size()) ? 32'(last_q[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] en_at(int i);
        return (i < en_q.size()) ? 32'(en_q[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        en_q.delete();
        inp_q.delete();
        exp_q.delete();
        last_q.delete();
        clr_cnt = 0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] spk, input logic [15:0] run);
        int n = 0;
        $display("cmd op=%0d spk=0x%02h run=%0d", op, spk, run);
        cmd_op = op; cmd_spk = spk; cmd_run = run; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int fall_cyc);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_val("idle_timeout", 32'(busy), 32'd0);
        fall_cyc = cyc;
        repeat (2) @(negedge clk);
        tick();
    endtask

    initial begin
        int fall;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_spk = 8'h00; cmd_run = 16'd0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", 32'(out_data), 32'd0);
        check_val("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        check_val("rst_net_clr", 32'(net_clr), 32'd1);
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_net_clr", 32'(net_clr), 32'd0);
        tick();

        // Accumulated spikes apply only to the first step of the run.
        send_cmd(2'd1, 8'h05, 16'd0);
        send_cmd(2'd1, 8'h80, 16'd0);
        clear_logs();
        send_cmd(2'd2, 8'h00, 16'd3);
        wait_idle(fall);
        check_val("t1_en_count", 32'(en_q.size()), 32'd3);
        check_val("t1_en_span", en_at(2) - en_at(0), 32'd2);
        check_val("t1_inp0", inp_at(0), 32'h85);
        check_val("t1_inp1", inp_at(1), 32'h00);
        check_val("t1_inp2", inp_at(2), 32'h00);
        check_val("t1_out_count", 32'(last_q.size()), 32'd3);
        check_val("t1_last0", last_at(0), 32'd0);
        check_val("t1_last1", last_at(1), 32'd0);
        check_val("t1_last2", last_at(2), 32'd1);
        check_val("t1_busy_fall", 32'(fall) - en_at(2), 32'd1);

        // Backpressure for 2 cycles after the first output.
        clear_logs();
        send_cmd(2'd2, 8'h00, 16'd4);
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check_val("t2_stall_en_a", 32'(net_en), 32'd0);
        check_val("t2_hold_a", 32'(out_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        check_val("t2_stall_en_b", 32'(net_en), 32'd0);
        check_val("t2_hold_b", 32'(out_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hDEAD_BEEF);
        tick();
        out_ready = 1'b1;
        wait_idle(fall);
        check_val("t2_en_count", 32'(en_q.size()), 32'd4);
        check_val("t2_en_gap", en_at(1) - en_at(0), 32'd3);
        check_val("t2_out_count", 32'(last_q.size()), 32'd4);
        check_val("t2_last2", last_at(2), 32'd0);
        check_val("t2_last3", last_at(3), 32'd1);

        // CLEAR discards pending spikes and holds net_clr for CLR_CYCLES.
        send_cmd(2'd1, 8'h01, 16'd0);
        clear_logs();
        send_cmd(2'd3, 8'h00, 16'd0);
        @(negedge clk);
        check_val("t3_clr_a", 32'(net_clr), 32'd1);
        check_val("t3_rdy_a", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check_val("t3_clr_b", 32'(net_clr), 32'd1);
        check_val("t3_rdy_b", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check_val("t3_clr_end", 32'(net_clr), 32'd0);
        check_val("t3_rdy_end", 32'(cmd_ready), 32'd1);
        tick();
        check_val("t3_clr_cycles", 32'(clr_cnt), 32'd2);
        clear_logs();
        send_cmd(2'd2, 8'h00, 16'd1);
        wait_idle(fall);
        check_val("t3_en_count", 32'(en_q.size()), 32'd1);
        check_val("t3_inp0", inp_at(0), 32'h00);
        check_val("t3_last0", last_at(0), 32'd1);

        // RUN 0 is a no-op.
        clear_logs();
        send_cmd(2'd2, 8'h00, 16'd0);
        repeat (3) @(negedge clk);
        check_val("t4_en_count", 32'(en_q.size()), 32'd0);
        check_val("t4_out_valid", 32'(out_valid), 32'd0);
        check_val("t4_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("t4_busy", 32'(busy), 32'd0);
        tick();

        // Reset in the middle of a long run.
        clear_logs();
        send_cmd(2'd2, 8'h00, 16'd10);
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        check_val("t5_rst_clr", 32'(net_clr), 32'd1);
        check_val("t5_rst_en", 32'(net_en), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_out_valid", 32'(out_valid), 32'd0);
        check_val("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        clear_logs();
        send_cmd(2'd2, 8'h00, 16'd2);
        wait_idle(fall);
        check_val("t5_en_count", 32'(en_q.size()), 32'd2);
        check_val("t5_out_count", 32'(last_q.size()), 32'd2);
        check_val("t5_last0", last_at(0), 32'd0);
        check_val("t5_last1", last_at(1), 32'd1);

`ifdef RUN_CTRL_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_logs();
        send_cmd(2'd2, 8'h00, 16'd5);
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        wait_idle(fall);
        check_val("st_steps", stat_steps, 32'd5);
        check_val("st_stalls", stat_stalls, 32'd3);
        send_cmd(2'd3, 8'h00, 16'd0);
        wait_idle(fall);
        check_val("st_steps_clr", stat_steps, 32'd5);
        check_val("st_stalls_clr", stat_stalls, 32'd3);
`endif

        check_val("inp_when_idle", 32'(inp_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/network_run_controller.md
Name: network_run_controller

Overview:
- Sequences the spiking network datapath from a command stream.
- Accepts SPIKE, RUN, CLEAR and NOP commands over a valid/ready handshake, then drives the network's per-step enable, clear and input vector.
- Streams one captured output vector per network step to the sink, and stalls the network when the sink backpressures.
- Sits between the instruction decoder and the network core, and replaces the free-running source/sink pairing where the host cannot keep up every cycle.

Parameters:
- NUM_INP, 8: width of the network input spike vector.
- NUM_OUT, 8: width of the network output spike vector.
- RUN_WIDTH, 16: width of the RUN step count.
- CLR_CYCLES, 2: number of cycles net_clr is held for a CLEAR command (must be at least 1).

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller accepts a command this cycle.
- cmd_op  input  2  opcode: 0 NOP, 1 SPIKE, 2 RUN, 3 CLEAR.
- cmd_spk  input  NUM_INP  spike vector for SPIKE.
- cmd_run  input  RUN_WIDTH  step count for RUN.
- net_en  output  1  advance the network one step this cycle.
- net_clr  output  1  clear network state.
- net_inp  output  NUM_INP  input spikes applied with net_en.
- net_out  input  NUM_OUT  network output for the current step, valid in the same cycle as net_en.
- out_valid  output  1  output vector available.
- out_ready  input  1  sink accepts the output vector.
- out_data  output  NUM_OUT  captured output vector.
- out_last  output  1  marks the final step of a RUN.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset: rst is sampled on the clk edge and overrides everything, including mid-RUN and mid-CLEAR. After reset:
  - state=IDLE; count=0; pending spikes=0.
  - out_valid=0, out_data=0, out_last=0; cmd_ready=1; busy=0.
- net_clr = rst OR (state==CLEAR), combinational, so a controller reset also clears the network.
- Command handshake: a command is accepted on a cycle with cmd_valid && cmd_ready. cmd_ready=1 only in IDLE and not in rst.
- State IDLE, per accepted command:
  - NOP: no effect.
  - SPIKE: pending <= pending | cmd_spk. Spikes accumulate across multiple SPIKEs.
  - RUN with cmd_run==0: no effect; no output is produced.
  - RUN with cmd_run>0: count <= cmd_run, first <= 1, go to RUN.
  - CLEAR: pending <= 0, ccnt <= CLR_CYCLES-1, go to CLEAR.
- State RUN:
  - step = !out_valid || out_ready; net_en = step.
  - net_inp = pending when first==1, otherwise 0. pending and first clear on the first stepped cycle.
  - On each stepped cycle: out_data <= net_out; out_valid <= 1; out_last <= (count==1); count <= count-1.
  - When a step is taken with count==1, go to IDLE.
  - Throughput is 1 step per cycle with out_ready held high. Output latency is 1 cycle after net_en.
  - A stalled step holds net_en=0; count and pending are unchanged.
- State CLEAR:
  - net_en=0, net_inp=0, net_clr=1.
  - When ccnt==0, go to IDLE; otherwise decrement ccnt.
  - net_clr is therefore high for exactly CLR_CYCLES cycles.
  - An output still pending may drain during CLEAR.
- Output register outside RUN: out_valid clears on out_ready when no new step is loaded. out_data and out_last hold while out_valid && !out_ready.
- Widths: count is RUN_WIDTH bits and never underflows. A RUN of 2^RUN_WIDTH-1 steps is legal.
- net_inp is always 0 when net_en=0.

Optional Feature:
- Macro: RUN_CTRL_STATS_EN.
- When defined:
  - Adds output port stat_steps, 32 bits: total steps taken (net_en cycles) since reset, saturating at 0xFFFFFFFF.
  - Adds output port stat_stalls, 32 bits: RUN cycles with net_en=0, saturating.
  - Both counters reset to 0 on rst. A CLEAR command does not reset them.
- When undefined: neither port nor either counter exists; behaviour is otherwise identical.

Test Plan:
- SPIKE 0x05, SPIKE 0x80, RUN 3, out_ready=1 -> net_en high for 3 consecutive cycles; net_inp 0x85 then 0x00, 0x00; 3 outputs with out_last only on the 3rd; busy falls the cycle after the last step.
- RUN 4 with out_ready low for 2 cycles after the first output -> net_en low during the stall; out_data holds; exactly 4 outputs and 4 net_en pulses in total; no output lost or duplicated.
- CLEAR with CLR_CYCLES=2 -> net_clr high for exactly 2 cycles; cmd_ready low for those cycles; a SPIKE 0x01 issued before the CLEAR does not appear on net_inp of a following RUN 1.
- RUN 0 -> no net_en pulse, no out_valid; cmd_ready stays high.
- rst asserted for 1 cycle in the middle of RUN 10 -> next cycle: IDLE, out_valid=0, net_clr=1 during rst, count=0; a following RUN 2 yields exactly 2 outputs.
- With RUN_CTRL_STATS_EN defined: RUN 5 with 3 stall cycles -> stat_steps=5, stat_stalls=3; after CLEAR both values are unchanged.
